// File: rtl/mc_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control unit.
// Contents:
//   state_t : 4-bit state encoding, FETCH (0) through JUMP (11)
//   OP_*    : opcodes the control unit recognises
//   ALUOP_*, SRCB_*, PCSRC_* : datapath mux/ALU selector encodings
//   ctrl_t  : per-state Moore control word produced by mc_ctrl_decode
package mc_ctrl_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMREAD  = 4'd3,
    MEMWB    = 4'd4,
    MEMWRITE = 4'd5,
    EXECUTE  = 4'd6,
    ALUWB    = 4'd7,
    BRANCH   = 4'd8,
    ADDIEX   = 4'd9,
    ADDIWB   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] SRCB_B     = 2'b00;
  localparam logic [1:0] SRCB_FOUR  = 2'b01;
  localparam logic [1:0] SRCB_IMM   = 2'b10;
  localparam logic [1:0] SRCB_IMMSH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // irwrite/pcwrite here are the raw per-state values; the top level
  // gates them with memory readiness and reset.
  typedef struct packed {
    logic       iord;
    logic       memwrite;
    logic       irwrite;
    logic       pcwrite;
    logic       branch;
    logic       regdst;
    logic       memtoreg;
    logic       regwrite;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] aluop;
    logic [1:0] pcsrc;
  } ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// Combinational state-to-control-word decoder for the multi-cycle control unit.
// Ports:
//   state : current FSM state code (4 bits)
//   ctrl  : Moore control word for that state; all-zero for unused codes
// Build option: MC_CTRL_JUMP_EN enables decoding of the JUMP state (11).
module mc_ctrl_decode
  import mc_ctrl_pkg::*;
(
  input  logic [3:0] state,
  output ctrl_t      ctrl
);

  // Start from an all-zero word so every unlisted output is a clean 0.
  always_comb begin
    ctrl = '0;
    case (state)
      FETCH: begin
        ctrl.alusrcb = SRCB_FOUR;
        ctrl.aluop   = ALUOP_ADD;
        ctrl.pcsrc   = PCSRC_ALU;
        ctrl.irwrite = 1'b1;
        ctrl.pcwrite = 1'b1;
      end
      DECODE: begin
        ctrl.alusrcb = SRCB_IMMSH;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMADR, ADDIEX: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_IMM;
        ctrl.aluop   = ALUOP_ADD;
      end
      MEMREAD: ctrl.iord = 1'b1;
      MEMWB: begin
        ctrl.memtoreg = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      MEMWRITE: begin
        ctrl.iord     = 1'b1;
        ctrl.memwrite = 1'b1;
      end
      EXECUTE: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_FUNCT;
      end
      ALUWB: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      BRANCH: begin
        ctrl.alusrca = 1'b1;
        ctrl.alusrcb = SRCB_B;
        ctrl.aluop   = ALUOP_SUB;
        ctrl.pcsrc   = PCSRC_ALUOUT;
        ctrl.branch  = 1'b1;
      end
      ADDIWB: ctrl.regwrite = 1'b1;
`ifdef MC_CTRL_JUMP_EN
      JUMP: begin
        ctrl.pcsrc   = PCSRC_JUMP;
        ctrl.pcwrite = 1'b1;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Main control unit for the multi-cycle MIPS datapath.
// Ports:
//   clk, rst         : rising-edge clock, asynchronous active-high reset
//   opcode           : instr[31:26] from the instruction register
//   zero             : ALU zero flag (branch condition)
//   mem_ready        : memory completes its access this cycle
//   iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite,
//   alusrca, alusrcb, aluop, pcsrc : datapath enables and mux selects
//   illegal_op       : one-cycle pulse in DECODE on an unsupported opcode
//   state            : current FSM state (debug)
//   instret          : retired-instruction counter, wraps modulo 2^CNT_W
// Build option: MC_CTRL_JUMP_EN adds the j instruction (state JUMP = 11);
// without it opcode 000010 is illegal and state 11 is unused.
module multicycle_control
  import mc_ctrl_pkg::*;
#(
  parameter int OP_W          = 6,
  parameter bit MEM_HANDSHAKE = 1'b1,
  parameter int CNT_W         = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OP_W-1:0]  opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             iord,
  output logic             memwrite,
  output logic             irwrite,
  output logic             pcen,
  output logic             regdst,
  output logic             memtoreg,
  output logic             regwrite,
  output logic             alusrca,
  output logic [1:0]       alusrcb,
  output logic [1:0]       aluop,
  output logic [1:0]       pcsrc,
  output logic             illegal_op,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instret
);

  state_t state_q, state_d;
  ctrl_t  ctrl;
  logic   rdy;
  logic   opcode_legal;
  logic   retire;
  logic   pcwrite;

  assign rdy = MEM_HANDSHAKE ? mem_ready : 1'b1;

  mc_ctrl_decode u_decode (
    .state (state_q),
    .ctrl  (ctrl)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= FETCH;
    else     state_q <= state_d;
  end

  // Next state; retire flags the completing step of a legal instruction.
  always_comb begin
    state_d      = state_q;
    opcode_legal = 1'b1;
    retire       = 1'b0;
    case (state_q)
      FETCH: if (rdy) state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_RTYPE:     state_d = EXECUTE;
          OP_LW, OP_SW: state_d = MEMADR;
          OP_BEQ:       state_d = BRANCH;
          OP_ADDI:      state_d = ADDIEX;
`ifdef MC_CTRL_JUMP_EN
          OP_J:         state_d = JUMP;
`endif
          default: begin
            state_d      = FETCH;
            opcode_legal = 1'b0;
          end
        endcase
      end
      MEMADR:  state_d = (opcode == OP_SW) ? MEMWRITE : MEMREAD;
      MEMREAD: if (rdy) state_d = MEMWB;
      MEMWRITE: begin
        if (rdy) begin
          state_d = FETCH;
          retire  = 1'b1;
        end
      end
      EXECUTE: state_d = ALUWB;
      ADDIEX:  state_d = ADDIWB;
`ifdef MC_CTRL_JUMP_EN
      MEMWB, ALUWB, BRANCH, ADDIWB, JUMP: begin
`else
      MEMWB, ALUWB, BRANCH, ADDIWB: begin
`endif
        state_d = FETCH;
        retire  = 1'b1;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)         instret <= '0;
    else if (retire) instret <= instret + CNT_W'(1);
  end

  // Only the FETCH write strobes wait on memory; JUMP's pcwrite is unconditional.
  assign pcwrite = ctrl.pcwrite & (rdy | (state_q != FETCH));

  // Strobes are masked by rst so nothing is written while reset is asserted.
  assign iord       = ctrl.iord;
  assign memwrite   = ctrl.memwrite & ~rst;
  assign irwrite    = ctrl.irwrite & rdy & ~rst;
  assign pcen       = (pcwrite | (ctrl.branch & zero)) & ~rst;
  assign regdst     = ctrl.regdst;
  assign memtoreg   = ctrl.memtoreg;
  assign regwrite   = ctrl.regwrite & ~rst;
  assign alusrca    = ctrl.alusrca;
  assign alusrcb    = ctrl.alusrcb;
  assign aluop      = ctrl.aluop;
  assign pcsrc      = ctrl.pcsrc;
  assign illegal_op = (state_q == DECODE) & ~opcode_legal & ~rst;
  assign state      = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control. Each instruction is modelled
// as the list of states it must visit (from the per-instruction cycle
// counts), with memory-wait states repeating while mem_ready is low.
// CNT_W is reduced to 4 so the random run wraps instret.
module tb_multicycle_control;

  localparam int CNT_W = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic [5:0]       opcode;
  logic             zero;
  logic             mem_ready;
  logic             iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca;
  logic [1:0]       alusrcb, aluop, pcsrc;
  logic             illegal_op;
  logic [3:0]       state;
  logic [CNT_W-1:0] instret;

  int               n_compared   = 0;
  int               n_mismatched = 0;
  logic [CNT_W-1:0] exp_instret;

  multicycle_control #(.OP_W(6), .MEM_HANDSHAKE(1'b1), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .iord       (iord),
    .memwrite   (memwrite),
    .irwrite    (irwrite),
    .pcen       (pcen),
    .regdst     (regdst),
    .memtoreg   (memtoreg),
    .regwrite   (regwrite),
    .alusrca    (alusrca),
    .alusrcb    (alusrcb),
    .aluop      (aluop),
    .pcsrc      (pcsrc),
    .illegal_op (illegal_op),
    .state      (state),
    .instret    (instret)
  );

  always #5 clk = ~clk;

  function automatic bit legal_op(input logic [5:0] op);
    bit ok;
    ok = (op == 6'b000000) || (op == 6'b100011) || (op == 6'b101011) ||
         (op == 6'b000100) || (op == 6'b001000);
`ifdef MC_CTRL_JUMP_EN
    if (op == 6'b000010) ok = 1'b1;
`endif
    return ok;
  endfunction

  // Expected {iord,memwrite,irwrite,pcen,regdst,memtoreg,regwrite,alusrca,
  //           alusrcb,aluop,pcsrc,illegal_op} from the per-state table.
  function automatic logic [14:0] exp_vec(input int st, input logic r, input logic z,
                                          input logic [5:0] op);
    logic io, mw, ir, pe, rd, mt, rw, sa, ill;
    logic [1:0] sb, ao, ps;
    {io, mw, ir, pe, rd, mt, rw, sa, ill} = '0;
    sb = 2'b00; ao = 2'b00; ps = 2'b00;
    case (st)
      0:  begin sb = 2'b01; ir = r; pe = r; end
      1:  begin sb = 2'b11; ill = !legal_op(op); end
      2:  begin sa = 1'b1; sb = 2'b10; end
      3:  io = 1'b1;
      4:  begin mt = 1'b1; rw = 1'b1; end
      5:  begin io = 1'b1; mw = 1'b1; end
      6:  begin sa = 1'b1; ao = 2'b10; end
      7:  begin rd = 1'b1; rw = 1'b1; end
      8:  begin sa = 1'b1; ao = 2'b01; ps = 2'b01; pe = z; end
      9:  begin sa = 1'b1; sb = 2'b10; end
      10: rw = 1'b1;
      11: begin ps = 2'b10; pe = 1'b1; end
      default: ;
    endcase
    return {io, mw, ir, pe, rd, mt, rw, sa, sb, ao, ps, ill};
  endfunction

  // Runs one instruction from FETCH. low_cycles >= 0: memory-wait states
  // see mem_ready low for that many cycles; < 0: random readiness.
  task automatic run_instr(input logic [5:0] op, input logic z, input int low_cycles,
                           output int mw_cycles);
    int          ph[$];
    bit          legal;
    bit          is_wait;
    int          st, waited, cycles;
    logic        r;
    logic [14:0] ev, av;
    ph = {0, 1};
    legal = 1'b1;
    case (op)
      6'b000000: ph = {ph, 6, 7};
      6'b100011: ph = {ph, 2, 3, 4};
      6'b101011: ph = {ph, 2, 5};
      6'b000100: ph = {ph, 8};
      6'b001000: ph = {ph, 9, 10};
`ifdef MC_CTRL_JUMP_EN
      6'b000010: ph = {ph, 11};
`endif
      default:   legal = 1'b0;
    endcase
    mw_cycles = 0; waited = 0; cycles = 0;
    while (ph.size() > 0) begin
      @(negedge clk);
      opcode = op;
      zero   = z;
      st = ph[0];
      is_wait = (st == 0) || (st == 3) || (st == 5);
      if (!is_wait)             r = 1'($urandom_range(0, 1));
      else if (low_cycles < 0)  r = (waited >= 4) ? 1'b1 : 1'($urandom_range(0, 1));
      else if (st == 0)         r = 1'b1;
      else                      r = (waited >= low_cycles);
      mem_ready = r;
      #1;
      n_compared++;
      if (state !== 4'(st)) begin
        n_mismatched++;
        $display("[TB] FAIL state op=%b: got %0d expected %0d", op, state, st);
      end
      ev = exp_vec(st, r, z, op);
      av = {iord, memwrite, irwrite, pcen, regdst, memtoreg, regwrite, alusrca,
            alusrcb, aluop, pcsrc, illegal_op};
      n_compared++;
      if (av !== ev) begin
        n_mismatched++;
        $display("[TB] FAIL controls op=%b st=%0d: got %b expected %b", op, st, av, ev);
      end
      n_compared++;
      if (instret !== exp_instret) begin
        n_mismatched++;
        $display("[TB] FAIL instret op=%b: got %0d expected %0d", op, instret, exp_instret);
      end
      if (memwrite === 1'b1) mw_cycles++;
      if (!is_wait || r) begin
        void'(ph.pop_front());
        waited = 0;
        if (ph.size() == 0 && legal) exp_instret = exp_instret + 1'b1;
      end else begin
        waited++;
      end
      cycles++;
      if (cycles > 60) begin
        n_compared++;
        n_mismatched++;
        $display("[TB] FAIL timeout op=%b: got %0d cycles expected at most 60", op, cycles);
        break;
      end
    end
  endtask

  // Holds FETCH one cycle (mem_ready low) and checks the retired count.
  task automatic idle_check(input logic [CNT_W-1:0] want, input string name);
    @(negedge clk);
    mem_ready = 1'b0;
    #1;
    n_compared++;
    if (state !== 4'd0 || instret !== want) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got state %0d instret %0d expected state 0 instret %0d",
               name, state, instret, want);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; mem_ready = 1'b1; opcode = 6'b100011; zero = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    n_compared++;
    if (state !== 4'd0 || instret !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_state: got state %0d instret %0d expected 0 0", state, instret);
    end
    n_compared++;
    if ({irwrite, pcen, memwrite, regwrite, illegal_op} !== 5'b0) begin
      n_mismatched++;
      $display("[TB] FAIL reset_strobes: got %b expected 00000",
               {irwrite, pcen, memwrite, regwrite, illegal_op});
    end
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
    exp_instret = '0;
  endtask

  task automatic test_lw;
    int mw;
    run_instr(6'b100011, 1'b0, 0, mw);
    idle_check(4'd1, "lw_instret");
  endtask

  task automatic test_sw_wait;
    int mw;
    run_instr(6'b101011, 1'b1, 3, mw);
    n_compared++;
    if (mw != 4) begin
      n_mismatched++;
      $display("[TB] FAIL sw_memwrite_cycles: got %0d expected 4", mw);
    end
    idle_check(4'd2, "sw_instret");
  endtask

  task automatic test_beq;
    int mw;
    run_instr(6'b000100, 1'b1, 0, mw);
    run_instr(6'b000100, 1'b0, 0, mw);
    idle_check(4'd4, "beq_instret");
  endtask

  task automatic test_illegal;
    int mw;
    run_instr(6'b111111, 1'b0, 0, mw);
    idle_check(4'd4, "illegal_instret");
  endtask

  task automatic test_jump;
    int mw;
    run_instr(6'b000010, 1'b0, 0, mw);
  endtask

  // Drives op to the given state with mem_ready held low there, then raises rst mid-cycle.
  task automatic test_async_reset(input logic [5:0] op, input int st_exp);
    @(negedge clk); opcode = op; mem_ready = 1'b1;
    @(negedge clk);
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk);
    #1;
    n_compared++;
    if (state !== 4'(st_exp) || instret !== exp_instret) begin
      n_mismatched++;
      $display("[TB] FAIL pre_reset op=%b: got state %0d instret %0d expected %0d %0d",
               op, state, instret, st_exp, exp_instret);
    end
    #1 rst = 1'b1;
    #1;
    n_compared++;
    if (state !== 4'd0 || {regwrite, memwrite, pcen, irwrite} !== 4'b0 || instret !== '0) begin
      n_mismatched++;
      $display("[TB] FAIL async_reset op=%b: got state %0d strobes %b instret %0d expected 0 0000 0",
               op, state, {regwrite, memwrite, pcen, irwrite}, instret);
    end
    exp_instret = '0;
    @(negedge clk);
    mem_ready = 1'b0;
    rst = 1'b0;
  endtask

  task automatic test_back_to_back;
    logic [5:0] pool [8];
    logic [5:0] op;
    int mw;
    pool = '{6'b000000, 6'b100011, 6'b101011, 6'b000100,
             6'b001000, 6'b000010, 6'b111111, 6'b000000};
    for (int i = 0; i < 40; i++) begin
      op = pool[$urandom_range(0, 7)];
      if (i % 9 == 8) op = 6'($urandom);
      run_instr(op, 1'($urandom_range(0, 1)), -1, mw);
    end
  endtask

  initial begin
    rst = 1'b1; opcode = '0; zero = 1'b0; mem_ready = 1'b0; exp_instret = '0;
    test_reset;
    test_lw;
    test_sw_wait;
    test_beq;
    test_illegal;
    test_jump;
    test_async_reset(6'b100011, 3);
    test_async_reset(6'b101011, 5);
    test_back_to_back;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
